// File: rtl/mult_accum_mem_ctrl.sv
// mult_accum_mem_ctrl: unsigned multiply / multiply-accumulate engine that streams results
// into write port B of a two-port memory and reads back a programmable window through
// read port A.
//
// Ports:
//   clk, rst                      single rising-edge clock, synchronous active-high reset
//   EN_mult / RDY_mult            operand pair handshake (mult_input0, mult_input1, mode)
//   EN_writeMem, writeMem_addr,   one write per result, PIPE cycles after the pair is accepted
//   writeMem_val
//   EN_blockRead / RDY_blockRead  block-read handshake (blockRead_start, blockRead_len)
//   EN_readMem, readMem_addr      read strobe and address towards the memory
//   readMem_val                   memory read data, MEM_RD_LAT cycles after EN_readMem
//   VALID_memVal, memVal_data     read-back word stream
//   full, wr_count                words written since reset (saturating at DEPTH)
module mult_accum_mem_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned PIPE       = 2,
  parameter int unsigned MEM_RD_LAT = 1,
  parameter bit          WRAP       = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN_mult,
  output logic              RDY_mult,
  input  logic [DATA_W-1:0] mult_input0,
  input  logic [DATA_W-1:0] mult_input1,
  input  logic              mode,
  output logic              EN_writeMem,
  output logic [ADDR_W-1:0] writeMem_addr,
  output logic [DATA_W-1:0] writeMem_val,
  input  logic              EN_blockRead,
  input  logic [ADDR_W-1:0] blockRead_start,
  input  logic [ADDR_W:0]   blockRead_len,
  output logic              RDY_blockRead,
  output logic              EN_readMem,
  output logic [ADDR_W-1:0] readMem_addr,
  input  logic [DATA_W-1:0] readMem_val,
  output logic              VALID_memVal,
  output logic [DATA_W-1:0] memVal_data,
  output logic              full,
  output logic [ADDR_W:0]   wr_count
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned CntW   = ADDR_W + 1;
  localparam int unsigned PendW  = ADDR_W + 2;
  localparam int unsigned DrainW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [CntW-1:0]   DepthCnt  = CntW'(DEPTH);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(MEM_RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StMult, StRead, StDrain} state_e;

  state_e state_q, state_d;

  // Multiplier pipeline: stage 0 holds the truncated product, the last stage feeds the write.
  logic [PIPE-1:0]   pipeVld_q;
  logic [PIPE-1:0]   pipeMode_q;
  logic [DATA_W-1:0] pipeProd_q [PIPE];

  logic [DATA_W-1:0] acc_q;
  logic [ADDR_W-1:0] wrPtr_q;
  logic [CntW-1:0]   wrCount_q;

  logic [ADDR_W-1:0]     rdStart_q;
  logic [CntW-1:0]       rdLen_q;
  logic [CntW-1:0]       rdIdx_q;
  logic [DrainW-1:0]     drainCnt_q;
  logic [MEM_RD_LAT-1:0] rdVld_q;

  logic [DATA_W-1:0] prodNow;
  logic [DATA_W-1:0] result;
  logic              wrFire;
  logic              pipeEmpty;
  logic [PendW-1:0]  inFlight;
  logic [PendW-1:0]  pending;
  logic              hasRoom;
  logic              lastIssue;

  logic rdyBlock, rdyMultBase, readIssue;
  logic blockFire, multFire;

  assign prodNow   = mult_input0 * mult_input1;
  assign wrFire    = pipeVld_q[PIPE-1];
  assign result    = pipeMode_q[PIPE-1] ? acc_q + pipeProd_q[PIPE-1] : pipeProd_q[PIPE-1];
  assign pipeEmpty = ~|pipeVld_q;
  assign lastIssue = (rdIdx_q == rdLen_q - CntW'(1));

  // Pairs still in the pipeline will be written, so they must be reserved against DEPTH.
  always_comb begin
    inFlight = '0;
    for (int i = 0; i < PIPE; i++) begin
      inFlight = inFlight + PendW'(pipeVld_q[i]);
    end
  end

  assign pending = PendW'(wrCount_q) + inFlight;
  assign hasRoom = WRAP || (pending < PendW'(DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (blockFire) begin
          state_d = StRead;
        end else if (multFire) begin
          state_d = StMult;
        end
      end
      StMult: begin
        if (!EN_mult && pipeEmpty) begin
          state_d = StIdle;
        end
      end
      StRead: begin
        if ((rdLen_q == '0) || lastIssue) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drainCnt_q == DrainLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; every output is forced low while rst is high.
  always_comb begin
    rdyBlock    = 1'b0;
    rdyMultBase = 1'b0;
    readIssue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        rdyBlock    = pipeEmpty;
        rdyMultBase = hasRoom;
      end
      StMult:  rdyMultBase = hasRoom;
      StRead:  readIssue   = (rdLen_q != '0);
      default: ;
    endcase

    RDY_blockRead = !rst && rdyBlock;
    blockFire     = EN_blockRead && RDY_blockRead;
    // A block read wins over an operand pair offered in the same cycle.
    RDY_mult      = !rst && rdyMultBase && !blockFire;
    multFire      = EN_mult && RDY_mult;

    EN_writeMem   = 1'b0;
    writeMem_addr = '0;
    writeMem_val  = '0;
    EN_readMem    = 1'b0;
    readMem_addr  = '0;
    VALID_memVal  = 1'b0;
    memVal_data   = '0;
    full          = 1'b0;
    wr_count      = '0;
    if (!rst) begin
      EN_writeMem   = wrFire;
      writeMem_addr = wrFire ? wrPtr_q : '0;
      writeMem_val  = wrFire ? result : '0;
      EN_readMem    = readIssue;
      readMem_addr  = readIssue ? rdStart_q + rdIdx_q[ADDR_W-1:0] : '0;
      VALID_memVal  = rdVld_q[MEM_RD_LAT-1];
      memVal_data   = rdVld_q[MEM_RD_LAT-1] ? readMem_val : '0;
      full          = (wrCount_q == DepthCnt);
      wr_count      = wrCount_q;
    end
  end

  // Pipeline payload needs no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    pipeProd_q[0] <= prodNow;
    pipeMode_q[0] <= mode;
    for (int i = 1; i < PIPE; i++) begin
      pipeProd_q[i] <= pipeProd_q[i-1];
      pipeMode_q[i] <= pipeMode_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipeVld_q  <= '0;
      acc_q      <= '0;
      wrPtr_q    <= '0;
      wrCount_q  <= '0;
      rdVld_q    <= '0;
      rdStart_q  <= '0;
      rdLen_q    <= '0;
      rdIdx_q    <= '0;
      drainCnt_q <= '0;
    end else begin
      pipeVld_q[0] <= multFire;
      for (int i = 1; i < PIPE; i++) begin
        pipeVld_q[i] <= pipeVld_q[i-1];
      end

      if (wrFire) begin
        // A mode=0 result restarts the running sum.
        acc_q   <= pipeMode_q[PIPE-1] ? result : '0;
        wrPtr_q <= wrPtr_q + ADDR_W'(1);
        if (wrCount_q != DepthCnt) begin
          wrCount_q <= wrCount_q + CntW'(1);
        end
      end

      rdVld_q[0] <= readIssue;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        rdVld_q[i] <= rdVld_q[i-1];
      end

      if (blockFire) begin
        rdStart_q <= blockRead_start;
        rdLen_q   <= (blockRead_len > DepthCnt) ? DepthCnt : blockRead_len;
        rdIdx_q   <= '0;
      end else if (readIssue) begin
        rdIdx_q <= rdIdx_q + CntW'(1);
      end

      drainCnt_q <= (state_q == StDrain) ? drainCnt_q + DrainW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_mult_accum_mem_ctrl.sv
// Directed bench for mult_accum_mem_ctrl: one WRAP=0 and one WRAP=1 instance share stimulus,
// each backed by a 64-word memory model with one cycle of read latency.
module tb_mult_accum_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN_mult, mode, EN_blockRead;
  logic [15:0] a, b;
  logic [5:0]  bStart;
  logic [6:0]  bLen;

  logic        rdyMult0, enWr0, rdyBlk0, enRd0, valid0, full0;
  logic [5:0]  wrAddr0, rdAddr0;
  logic [15:0] wrVal0, memData0;
  logic [6:0]  wrCnt0;
  logic [15:0] rd0;

  logic        rdyMult1, enWr1, rdyBlk1, enRd1, valid1, full1;
  logic [5:0]  wrAddr1, rdAddr1;
  logic [15:0] wrVal1, memData1;
  logic [6:0]  wrCnt1;
  logic [15:0] rd1;

  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];

  int nVec = 0;
  int nErr = 0;
  int cyc  = 0;

  int nAcc0, nWr0, nWr1, firstAccCyc0, firstWrCyc0, lastWrCyc0, lastWrAddr0;
  int rdAddrQ[$];
  int rdCycQ[$];
  int valQ[$];
  int valCycQ[$];

  always #5 clk = ~clk;

  mult_accum_mem_ctrl #(
    .DATA_W(16), .ADDR_W(6), .PIPE(2), .MEM_RD_LAT(1), .WRAP(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .EN_mult(EN_mult), .RDY_mult(rdyMult0),
    .mult_input0(a), .mult_input1(b), .mode(mode),
    .EN_writeMem(enWr0), .writeMem_addr(wrAddr0), .writeMem_val(wrVal0),
    .EN_blockRead(EN_blockRead), .blockRead_start(bStart), .blockRead_len(bLen),
    .RDY_blockRead(rdyBlk0),
    .EN_readMem(enRd0), .readMem_addr(rdAddr0), .readMem_val(rd0),
    .VALID_memVal(valid0), .memVal_data(memData0),
    .full(full0), .wr_count(wrCnt0)
  );

  mult_accum_mem_ctrl #(
    .DATA_W(16), .ADDR_W(6), .PIPE(2), .MEM_RD_LAT(1), .WRAP(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .EN_mult(EN_mult), .RDY_mult(rdyMult1),
    .mult_input0(a), .mult_input1(b), .mode(mode),
    .EN_writeMem(enWr1), .writeMem_addr(wrAddr1), .writeMem_val(wrVal1),
    .EN_blockRead(EN_blockRead), .blockRead_start(bStart), .blockRead_len(bLen),
    .RDY_blockRead(rdyBlk1),
    .EN_readMem(enRd1), .readMem_addr(rdAddr1), .readMem_val(rd1),
    .VALID_memVal(valid1), .memVal_data(memData1),
    .full(full1), .wr_count(wrCnt1)
  );

  // Memory models: synchronous write, registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (enWr0) mem0[wrAddr0] <= wrVal0;
    if (enRd0) rd0 <= mem0[rdAddr0];
    if (enWr1) mem1[wrAddr1] <= wrVal1;
    if (enRd1) rd1 <= mem1[rdAddr1];
  end

  // Event log, sampled mid-cycle; emptied whenever rst is seen high.
  always @(negedge clk) begin
    if (rst) begin
      nAcc0 <= 0;
      nWr0  <= 0;
      nWr1  <= 0;
      rdAddrQ.delete();
      rdCycQ.delete();
      valQ.delete();
      valCycQ.delete();
    end else begin
      if (EN_mult && rdyMult0) begin
        if (nAcc0 == 0) firstAccCyc0 <= cyc;
        nAcc0 <= nAcc0 + 1;
      end
      if (enWr0) begin
        if (nWr0 == 0) firstWrCyc0 <= cyc;
        lastWrCyc0  <= cyc;
        lastWrAddr0 <= int'(wrAddr0);
        nWr0        <= nWr0 + 1;
      end
      if (enWr1) nWr1 <= nWr1 + 1;
      if (enRd0) begin
        rdAddrQ.push_back(int'(rdAddr0));
        rdCycQ.push_back(cyc);
      end
      if (valid0) begin
        valQ.push_back(int'(memData0));
        valCycQ.push_back(cyc);
      end
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    EN_mult = 1'b0; EN_blockRead = 1'b0; mode = 1'b0;
    a = '0; b = '0; bStart = '0; bLen = '0;
    cyc1();
    cyc1();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp1[9] = '{9, 16, 21, 24, 25, 24, 21, 16, 9};
    int exp2[11] = '{9, 25, 46, 70, 95, 119, 140, 156, 165, 6, 5};
    int exp3[3] = '{16'h0001, 16'hFF00, 16'h0000};
    int expA[4] = '{62, 63, 0, 1};

    // Reset state
    rst = 1'b1;
    EN_mult = 1'b0; EN_blockRead = 1'b0; mode = 1'b0;
    a = '0; b = '0; bStart = '0; bLen = '0;
    cyc1();
    @(negedge clk);
    chk("rst_outputs_zero", {rdyMult0, rdyBlk0, enWr0, wrAddr0, wrVal0, enRd0, rdAddr0,
                             valid0, memData0, full0, wrCnt0}, 64'd0);
    cyc1();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", {rdyMult0, rdyBlk0, full0, wrCnt0}, {1'b1, 1'b1, 1'b0, 7'd0});
    cyc1();

    // mode=0 products, one pair per cycle
    for (int i = 1; i <= 9; i++) begin
      EN_mult = 1'b1; mode = 1'b0; a = 16'(i); b = 16'(10 - i);
      cyc1();
    end
    EN_mult = 1'b0;
    repeat (5) cyc1();
    chk("t1_nwr", nWr0, 9);
    chk("t1_latency", firstWrCyc0 - firstAccCyc0, 2);
    chk("t1_back2back", lastWrCyc0 - firstWrCyc0, 8);
    chk("t1_wr_count", wrCnt0, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("t1_mem%0d", i), mem0[i], exp1[i]);

    // mode=1 running sum, then a mode=0 pair restarts it
    doReset();
    for (int i = 1; i <= 9; i++) begin
      EN_mult = 1'b1; mode = 1'b1; a = 16'(i); b = 16'(10 - i);
      cyc1();
    end
    mode = 1'b0; a = 16'd2; b = 16'd3;
    cyc1();
    mode = 1'b1; a = 16'd1; b = 16'd5;
    cyc1();
    EN_mult = 1'b0;
    repeat (5) cyc1();
    for (int i = 0; i < 11; i++) chk($sformatf("t2_mem%0d", i), mem0[i], exp2[i]);

    // Modular overflow
    doReset();
    EN_mult = 1'b1; mode = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
    cyc1();
    mode = 1'b1; a = 16'hFF00; b = 16'h0001;
    cyc1();
    a = 16'h0100; b = 16'h0001;
    cyc1();
    EN_mult = 1'b0;
    repeat (5) cyc1();
    for (int i = 0; i < 3; i++) chk($sformatf("t3_mem%0d", i), mem0[i], exp3[i]);

    // Fill all 64 words, then block reads
    doReset();
    for (int i = 0; i < 64; i++) begin
      EN_mult = 1'b1; mode = 1'b0; a = 16'(i); b = 16'd3;
      cyc1();
    end
    EN_mult = 1'b0;
    repeat (5) cyc1();
    chk("t4_nwr", nWr0, 64);
    chk("t4_last_addr", lastWrAddr0, 63);
    chk("t4_full", {full0, wrCnt0, rdyMult0}, {1'b1, 7'd64, 1'b0});
    chk("t4_rdy_block", rdyBlk0, 1'b1);

    EN_blockRead = 1'b1; bStart = 6'd62; bLen = 7'd4;
    cyc1();
    EN_blockRead = 1'b0;
    repeat (8) cyc1();
    chk("t4_nissue", rdAddrQ.size(), 4);
    chk("t4_nvalid", valQ.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_addr%0d", i), rdAddrQ[i], expA[i]);
      chk($sformatf("t4_issue_cyc%0d", i), rdCycQ[i] - rdCycQ[0], i);
      chk($sformatf("t4_val_lat%0d", i), valCycQ[i] - rdCycQ[i], 1);
      chk($sformatf("t4_data%0d", i), valQ[i], 3 * expA[i]);
    end

    // Zero-length read: READ then DRAIN, idle again three cycles after the accept
    EN_blockRead = 1'b1; bStart = 6'd5; bLen = 7'd0;
    cyc1();
    EN_blockRead = 1'b0;
    @(negedge clk);
    chk("t4_len0_c1", rdyBlk0, 1'b0);
    cyc1();
    @(negedge clk);
    chk("t4_len0_c2", rdyBlk0, 1'b0);
    cyc1();
    @(negedge clk);
    chk("t4_len0_c3", rdyBlk0, 1'b1);
    cyc1();
    chk("t4_len0_noissue", rdAddrQ.size(), 4);
    chk("t4_len0_novalid", valQ.size(), 4);

    // Oversized length is clamped to 64 words
    EN_blockRead = 1'b1; bStart = 6'd0; bLen = 7'd100;
    cyc1();
    EN_blockRead = 1'b0;
    repeat (70) cyc1();
    chk("t4_clamp_nissue", rdAddrQ.size(), 68);
    chk("t4_clamp_nvalid", valQ.size(), 68);
    chk("t4_clamp_last", rdAddrQ[67], 63);

    // 70 pairs offered: WRAP=0 stops at 64, WRAP=1 overwrites from address 0
    doReset();
    for (int i = 0; i < 70; i++) begin
      EN_mult = 1'b1; mode = 1'b0; a = 16'(i + 1); b = 16'd1;
      cyc1();
    end
    chk("t5_rdy_mult_full", rdyMult0, 1'b0);
    EN_mult = 1'b0;
    repeat (5) cyc1();
    chk("t5_nacc0", nAcc0, 64);
    chk("t5_nwr0", nWr0, 64);
    chk("t5_full0", {full0, wrCnt0}, {1'b1, 7'd64});
    chk("t5_mem0_0", mem0[0], 1);
    chk("t5_mem0_63", mem0[63], 64);
    chk("t5_nwr1", nWr1, 70);
    chk("t5_wr_count1", wrCnt1, 64);
    for (int i = 0; i < 6; i++) chk($sformatf("t5_mem1_%0d", i), mem1[i], 65 + i);
    chk("t5_mem1_6", mem1[6], 7);

    // Reset in the middle of a block read
    doReset();
    EN_blockRead = 1'b1; bStart = 6'd0; bLen = 7'd8;
    cyc1();
    EN_blockRead = 1'b0;
    cyc1();
    cyc1();
    chk("t6_issued_before_rst", rdAddrQ.size(), 2);
    rst = 1'b1;
    cyc1();
    rst = 1'b0;
    repeat (10) cyc1();
    chk("t6_no_issue_after_rst", rdAddrQ.size(), 0);
    chk("t6_no_valid_after_rst", valQ.size(), 0);

    // Reset with products still in the pipeline
    EN_mult = 1'b1; mode = 1'b0; a = 16'd7; b = 16'd7;
    cyc1();
    a = 16'd8;
    cyc1();
    EN_mult = 1'b0;
    rst = 1'b1;
    cyc1();
    rst = 1'b0;
    repeat (6) cyc1();
    chk("t6_no_write_after_rst", nWr0, 0);
    chk("t6_wr_count", wrCnt0, 0);
    EN_mult = 1'b1; a = 16'd5; b = 16'd5;
    cyc1();
    EN_mult = 1'b0;
    repeat (4) cyc1();
    chk("t6_nwr", nWr0, 1);
    chk("t6_addr0", lastWrAddr0, 0);
    chk("t6_mem0", mem0[0], 25);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
